// File: rtl/matrix_scan_driver.sv
// Column-multiplexed LED dot-matrix driver with a double-buffered frame store and blink.
// Each column stays lit for SCAN_DIV cycles. A pending shadow frame is promoted only at the end of a scan.
module matrix_scan_driver #(
  parameter int COLS         = 5,
  parameter int ROWS         = 7,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 50
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 blink,
  input  logic [COLS*ROWS-1:0] frame_in,
  input  logic                 frame_valid,
  output logic                 frame_ready,
  output logic [COLS-1:0]      col_en,
  output logic [ROWS-1:0]      row_out,
  output logic                 frame_done
);

  localparam int FW = COLS * ROWS;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [FW-1:0]   active_q, active_d;
  logic [FW-1:0]   shadow_q, shadow_d;
  logic            shadow_full_q, shadow_full_d;
  logic            run_q, run_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [CW-1:0]   col_q, col_d;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            blank_q, blank_d;
  logic            frame_ready_q, frame_ready_d;
  logic [COLS-1:0] col_en_q, col_en_d;
  logic [ROWS-1:0] row_out_q, row_out_d;
  logic            frame_done_q, frame_done_d;

  logic            load;
  logic            term_cnt;
  logic            scan_end;
  logic [ROWS-1:0] group_sel;

  // Handshake: a frame transfers on a rising edge where frame_valid && frame_ready.
  // frame_ready is high exactly while the shadow buffer is empty.
  always_comb begin
    active_d      = active_q;
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
    run_d         = run_q;
    presc_d       = presc_q;
    col_d         = col_q;
    blink_cnt_d   = blink_cnt_q;
    blank_d       = blank_q;
    group_sel     = '0;

    load     = frame_valid && frame_ready_q;
    term_cnt = enable && run_q && (presc_q == PRESC_LAST);
    scan_end = term_cnt && (col_q == COL_LAST);

    if (!enable) begin
      run_d       = 1'b0;
      presc_d     = '0;
      col_d       = '0;
      blink_cnt_d = '0;
      blank_d     = 1'b0;
    end else if (!run_q) begin
      // The first enabled edge only lights column 0, so it gets a full SCAN_DIV period.
      run_d = 1'b1;
    end else begin
      presc_d = term_cnt ? '0 : presc_q + 1'b1;
      if (term_cnt) col_d = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
      if (scan_end) begin
        if (blink_cnt_q == BLINK_LAST) begin
          blink_cnt_d = '0;
          blank_d     = !blank_q;
        end else begin
          blink_cnt_d = blink_cnt_q + 1'b1;
        end
      end
    end

    // A swap and a load can never coincide: a swap needs a full shadow and a load needs an empty one.
    if (scan_end && shadow_full_q) begin
      active_d      = shadow_q;
      shadow_full_d = 1'b0;
    end else if (load) begin
      shadow_d      = frame_in;
      shadow_full_d = 1'b1;
    end

    for (int c = 0; c < COLS; c++) begin
      if (col_d == CW'(c)) group_sel = active_d[FW-1-c*ROWS -: ROWS];
    end

    col_en_d = '0;
    for (int c = 0; c < COLS; c++) begin
      col_en_d[c] = enable && (col_d == CW'(c));
    end
    row_out_d     = (enable && !(blink && blank_d)) ? group_sel : '0;
    frame_done_d  = scan_end;
    frame_ready_d = !shadow_full_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q      <= '0;
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
      run_q         <= 1'b0;
      presc_q       <= '0;
      col_q         <= '0;
      blink_cnt_q   <= '0;
      blank_q       <= 1'b0;
      frame_ready_q <= 1'b1;
      col_en_q      <= '0;
      row_out_q     <= '0;
      frame_done_q  <= 1'b0;
    end else begin
      active_q      <= active_d;
      shadow_q      <= shadow_d;
      shadow_full_q <= shadow_full_d;
      run_q         <= run_d;
      presc_q       <= presc_d;
      col_q         <= col_d;
      blink_cnt_q   <= blink_cnt_d;
      blank_q       <= blank_d;
      frame_ready_q <= frame_ready_d;
      col_en_q      <= col_en_d;
      row_out_q     <= row_out_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign frame_ready = frame_ready_q;
  assign col_en      = col_en_q;
  assign row_out     = row_out_q;
  assign frame_done  = frame_done_q;

endmodule
